pipelined_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor. Successor to the fixed-width ripple adder.
- The carry chain is split into STAGES registered segments, so WIDTH can grow without lengthening the critical path.
- Adds a valid/ready handshake with backpressure, a subtract mode, and a zero flag.
- Sits between operand-issue logic and result writeback in the ALU datapath.

---
 rtl/pipelined_addsub.sv | 141 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor with valid/ready handshake
// Optional PIPELINED_ADDSUB_SAT_EN clamps the result on signed overflow in the final stage.
module pipelined_addsub #(
    parameter int WIDTH  = 33,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;

    // A stage advances when its successor is empty or itself advancing; the last stage drains on out_ready.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = v[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = v[k] & (~v[k+1] | adv[k+1]);
        end
    end

    assign in_ready  = ~v[0] | adv[0];
    assign out_valid = v[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG - 1 : WIDTH - 1;

        logic [WIDTH-1:0] ia;
        logic [WIDTH-1:0] ib;
        logic [WIDTH-1:0] is;
        logic [WIDTH-1:0] ns;
        logic             ic;
        logic             nc;
        logic             ld;
        logic             vr;

        if (k == 0) begin : g_first
            assign ia = a;
            assign ib = sub ? ~b : b;
            assign is = '0;
            assign ic = cin ^ sub;
            assign ld = in_valid & in_ready;
        end else begin : g_next
            assign ia = g_stage[k-1].g_reg.ra;
            assign ib = g_stage[k-1].g_reg.rb;
            assign is = g_stage[k-1].g_reg.rs;
            assign ic = g_stage[k-1].g_reg.rc;
            assign ld = adv[k-1];
        end

        if (LO >= WIDTH) begin : g_empty
            assign ns = is;
            assign nc = ic;
        end else begin : g_add
            // Operands are masked to this segment; the carry-in is injected at its lowest bit.
            localparam logic [WIDTH-1:0] M  = ({WIDTH{1'b1}} >> (WIDTH - 1 - HI)) & ({WIDTH{1'b1}} << LO);
            localparam logic [WIDTH:0]   CI = {{WIDTH{1'b0}}, 1'b1} << LO;
            logic [WIDTH:0] t;
            assign t  = {1'b0, ia & M} + {1'b0, ib & M} + (ic ? CI : '0);
            assign ns = (is & ~M) | WIDTH'(t & {1'b0, M});
            assign nc = t[HI+1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vr <= 1'b0;
            end else begin
                vr <= ld | (vr & ~adv[k]);
            end
        end
        assign v[k] = vr;

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic [WIDTH-1:0] rs;
            logic             rc;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ra <= '0;
                    rb <= '0;
                    rs <= '0;
                    rc <= 1'b0;
                end else if (ld) begin
                    ra <= ia;
                    rb <= ib;
                    rs <= ns;
                    rc <= nc;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] fs;
            logic             fo;
            logic [WIDTH-1:0] sum_r;
            logic             cout_r;
            logic             ovf_r;
            logic             zero_r;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            assign fo = ia[WIDTH-1] ^ ib[WIDTH-1] ^ ns[WIDTH-1] ^ nc;
`ifdef PIPELINED_ADDSUB_SAT_EN
            assign fs = fo ? {~ns[WIDTH-1], {(WIDTH-1){ns[WIDTH-1]}}} : ns;
`else
            assign fs = ns;
`endif
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_r  <= '0;
                    cout_r <= 1'b0;
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (ld) begin
                    sum_r  <= fs;
                    cout_r <= nc;
                    ovf_r  <= fo;
                    zero_r <= (fs == '0);
                end
            end

            assign sum      = sum_r;
            assign cout     = cout_r;
            assign overflow = ovf_r;
            assign zero     = zero_r;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed self-checking bench for pipelined_addsub (WIDTH=33, STAGES=3)
module tb_pipelined_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] a;
    logic [32:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_addsub #(.WIDTH(33), .STAGES(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [32:0] ta, input logic [32:0] tb,
                          input logic tcin, input logic tsub, input logic [32:0] esum,
                          input logic ecout, input logic eovf, input logic ezero);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_b({tag, "_in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0; a = '1; b = '1; cin = ~tcin; sub = ~tsub;
        step();
        check_b({tag, "_early"}, out_valid, 1'b0);
        step();
        check_b({tag, "_valid"}, out_valid, 1'b1);
        check_w({tag, "_sum"}, sum, esum);
        check_b({tag, "_cout"}, cout, ecout);
        check_b({tag, "_ovf"}, overflow, eovf);
        check_b({tag, "_zero"}, zero, ezero);
        step();
    endtask

    logic [32:0] bp_a [6];
    logic [32:0] bp_b [6];
    logic [32:0] bp_e [6];
    int sent;
    int got;
    logic acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_b("rst_out_valid", out_valid, 1'b0);
        check_w("rst_sum", sum, 33'h0);
        check_b("rst_cout", cout, 1'b0);
        check_b("rst_ovf", overflow, 1'b0);
        check_b("rst_zero", zero, 1'b0);
        check_b("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        step();

        run_op("wrap_zero", 33'h1_FFFF_FFFF, 33'h1, 1'b0, 1'b0, 33'h0, 1'b1, 1'b0, 1'b1);
`ifdef PIPELINED_ADDSUB_SAT_EN
        run_op("pos_ovf", 33'h0_FFFF_FFFF, 33'h1, 1'b0, 1'b0, 33'h0_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("neg_ovf", 33'h1_0000_0000, 33'h1, 1'b0, 1'b1, 33'h1_0000_0000, 1'b1, 1'b1, 1'b0);
`else
        run_op("pos_ovf", 33'h0_FFFF_FFFF, 33'h1, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op("neg_ovf", 33'h1_0000_0000, 33'h1, 1'b0, 1'b1, 33'h0_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
        run_op("sub_5_7", 33'h5, 33'h7, 1'b0, 1'b1, 33'h1_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_5_7_b", 33'h5, 33'h7, 1'b1, 1'b1, 33'h1_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_op("seg01_carry", 33'h7FF, 33'h0, 1'b1, 1'b0, 33'h800, 1'b0, 1'b0, 1'b0);
        run_op("seg12_carry", 33'h3F_FFFF, 33'h0, 1'b1, 1'b0, 33'h40_0000, 1'b0, 1'b0, 1'b0);
        run_op("sub_equal", 33'h123, 33'h123, 1'b0, 1'b1, 33'h0, 1'b1, 1'b0, 1'b1);

        bp_a = '{33'h7FF, 33'h3F_FFFF, 33'h1_FFFF_FFFF, 33'h0_1234_5678, 33'h1_0000_0001, 33'h0};
        bp_b = '{33'h1, 33'h1, 33'h2, 33'h0_1111_1111, 33'h1_FFFF_FFFF, 33'h3};
        bp_e = '{33'h800, 33'h40_0000, 33'h1, 33'h0_2345_6789, 33'h1_0000_0000, 33'h3};
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            a = bp_a[sent < 6 ? sent : 0];
            b = bp_b[sent < 6 ? sent : 0];
            cin = 1'b0; sub = 1'b0;
            #1;
            if (cyc == 3) begin
                check_b("bp_full_in_ready", in_ready, 1'b0);
                check_w("bp_accepts", 33'(sent), 33'd3);
            end
            if (cyc == 3 || cyc == 4) begin
                check_b("bp_stall_valid", out_valid, 1'b1);
                check_w("bp_stall_sum", sum, bp_e[0]);
            end
            if (cyc == 5) check_b("bp_full_accept", in_ready, 1'b1);
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                check_w("bp_result", sum, bp_e[got]);
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check_w("bp_count", 33'(got), 33'd6);
        step();
        check_b("bp_drained", out_valid, 1'b0);

        out_ready = 1'b0;
        a = 33'h1; b = 33'h2; in_valid = 1'b1;
        step();
        a = 33'h3; b = 33'h4;
        step();
        in_valid = 1'b0;
        step();
        check_b("mid_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_b("mid_rst_valid", out_valid, 1'b0);
        check_w("mid_rst_sum", sum, 33'h0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_b("mid_no_stale", out_valid, 1'b0);
        end
        run_op("after_rst", 33'h0_0AAA_AAAA, 33'h0_0555_5555, 1'b0, 1'b0, 33'h0_0FFF_FFFF, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
